uart_rx_frontend: RTL and testbench

//  16x-oversampled UART receiver, 8N1, LSB first. Sits upstream of the peripheral RX buffer.

---
 rtl/uart_rx_frontend.sv | 96 +++++++++
 tb/tb_uart_rx_frontend.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampled 8N1 UART receiver with majority vote, valid/ready output
// register and framing-error, overrun and line-break reporting.
module uart_rx_frontend #(
    parameter int TICK_DIV = 651,
    parameter bit SYNC_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       line_break,
    output logic       busy
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t      state, state_n;
    logic          sync1, rx_s;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    s_cnt;
    logic [2:0]    bit_idx;
    logic          s7, s8;
    logic [7:0]    shreg;
    logic          tick, maj, at9, at15, deliver, ferr, start_go;
    assign tick     = tick_cnt == TW'(TICK_DIV - 1);
    assign maj      = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign at9      = tick && s_cnt == 4'd9;
    assign at15     = tick && s_cnt == 4'd15;
    assign start_go = state == IDLE && !rx_s;
    assign busy     = state != IDLE;
    always_comb begin
        state_n = state;
        deliver = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE:  state_n = rx_s ? IDLE : START;
            START: state_n = (at9 && maj) ? IDLE : at15 ? DATA : START;
            DATA:  state_n = (at15 && bit_idx == 3'd7) ? STOP : DATA;
            STOP: begin
                deliver = at9 && maj;
                ferr    = at9 && !maj;
                state_n = !at9 ? STOP : maj ? IDLE : BRK;
            end
            BRK:     state_n = rx_s ? IDLE : BRK;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= SYNC_INIT;
            rx_s       <= SYNC_INIT;
            state      <= IDLE;
            tick_cnt   <= '0;
            s_cnt      <= '0;
            bit_idx    <= '0;
            s7         <= 1'b0;
            s8         <= 1'b0;
            shreg      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            line_break <= 1'b0;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            state <= state_n;
            // Restart the tick phase on the start edge so samples land mid-bit
            if (start_go) begin
                tick_cnt <= '0;
                s_cnt    <= '0;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick && busy) s_cnt <= s_cnt + 4'd1;
            end
            if (tick && s_cnt == 4'd7) s7 <= rx_s;
            if (tick && s_cnt == 4'd8) s8 <= rx_s;
            if (state == START && at15) bit_idx <= '0;
            else if (state == DATA && at15) bit_idx <= bit_idx + 3'd1;
            if (state == DATA && at9) shreg <= {maj, shreg[7:1]};
            frame_err <= ferr;
            overrun   <= deliver && out_valid && !out_ready;
            if (ferr) line_break <= 1'b1;
            else if (state == BRK && rx_s) line_break <= 1'b0;
            if (deliver && (!out_valid || out_ready)) begin
                out_data  <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed scenario tasks for uart_rx_frontend with TICK_DIV=4
// (64 clk per bit); each task checks its own expected values inline.
module tb_uart_rx_frontend;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid, frame_err, overrun, line_break, busy;
    int         n_tests = 0;
    int         n_fail = 0;
    int         valid_cycles, fe_cnt, ov_cnt, busy_seen;
    logic [7:0] last_data;

    uart_rx_frontend #(.TICK_DIV(4), .SYNC_INIT(1'b1)) dut (
        .clk(clk), .reset(reset), .rx(rx), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun),
        .line_break(line_break), .busy(busy)
    );

    always #5 clk = ~clk;

    // Observation counters, sampled away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                valid_cycles++;
                last_data = out_data;
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (busy) busy_seen = 1;
        end
    end

    task automatic clear_obs();
        @(posedge clk);
        valid_cycles = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        busy_seen = 0;
        last_data = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // One bit period; glitch adds a 1-clk low at the bit edge and inverts the sample-7 tick
    task automatic drive_bit(input logic v, input bit glitch);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (glitch && i == 0) rx = 1'b0;
            else if (glitch && i >= 30 && i <= 33) rx = ~v;
            else rx = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit glitch);
        drive_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
        drive_bit(stop_v, glitch);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_data, out_valid, frame_err, overrun, line_break, busy} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got data=%h v=%b fe=%b ov=%b lb=%b busy=%b exp all 0",
                     out_data, out_valid, frame_err, overrun, line_break, busy);
        end
        reset = 1'b0;
        idle(10);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        clear_obs();
        send_frame(8'h55, 1'b1, 1'b0);
        idle(20);
        n_tests++;
        if (valid_cycles !== 1) begin
            n_fail++;
            $display("FAIL basic_valid_cycles got %0d exp 1", valid_cycles);
        end
        n_tests++;
        if (last_data !== 8'h55) begin
            n_fail++;
            $display("FAIL basic_data got %h exp 55", last_data);
        end
        n_tests++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            n_fail++;
            $display("FAIL basic_errs got fe=%0d ov=%0d exp 0 0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        send_frame(8'hA3, 1'b1, 1'b1);
        idle(20);
        n_tests++;
        if (valid_cycles !== 1 || last_data !== 8'hA3) begin
            n_fail++;
            $display("FAIL glitch_data got cycles=%0d data=%h exp 1 a3", valid_cycles, last_data);
        end
        n_tests++;
        if (fe_cnt !== 0) begin
            n_fail++;
            $display("FAIL glitch_fe got %0d exp 0", fe_cnt);
        end
    endtask

    task automatic test_false_start();
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        @(negedge clk);
        rx = 1'b1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL false_start_busy_rise got %b exp 1", busy);
        end
        idle(60);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL false_start_busy_fall got %b exp 0", busy);
        end
        n_tests++;
        if (valid_cycles !== 0 || fe_cnt !== 0) begin
            n_fail++;
            $display("FAIL false_start_outs got v=%0d fe=%0d exp 0 0", valid_cycles, fe_cnt);
        end
    endtask

    task automatic test_break();
        clear_obs();
        send_frame(8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        n_tests++;
        if (line_break !== 1'b1) begin
            n_fail++;
            $display("FAIL break_level got %b exp 1", line_break);
        end
        n_tests++;
        if (fe_cnt !== 1 || valid_cycles !== 0) begin
            n_fail++;
            $display("FAIL break_fe got fe=%0d v=%0d exp 1 0", fe_cnt, valid_cycles);
        end
        idle(6);
        n_tests++;
        if (line_break !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_clear got lb=%b busy=%b exp 0 0", line_break, busy);
        end
        idle(20);
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        clear_obs();
        send_frame(8'h11, 1'b1, 1'b0);
        idle(20);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_first got v=%b data=%h exp 1 11", out_valid, out_data);
        end
        send_frame(8'h22, 1'b1, 1'b0);
        idle(20);
        n_tests++;
        if (ov_cnt !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulse got %0d exp 1", ov_cnt);
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_hold got v=%b data=%h exp 1 11", out_valid, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_accept got v=%b data=%h exp 0 11", out_valid, out_data);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h7E;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rx = d[4];
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_busy got %b exp 1", busy);
        end
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_data, out_valid, frame_err, overrun, line_break, busy} !== 13'h0) begin
            n_fail++;
            $display("FAIL midframe_reset got data=%h v=%b fe=%b ov=%b lb=%b busy=%b exp all 0",
                     out_data, out_valid, frame_err, overrun, line_break, busy);
        end
        reset = 1'b0;
        idle(10);
        clear_obs();
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);
        n_tests++;
        if (valid_cycles !== 1 || last_data !== 8'h3C || fe_cnt !== 0) begin
            n_fail++;
            $display("FAIL midframe_next got v=%0d data=%h fe=%0d exp 1 3c 0",
                     valid_cycles, last_data, fe_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_false_start();
        test_break();
        test_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
